logit_argmax: RTL and testbench

LOGIT_ARGMAX -- requirements
Module: logit_argmax

---
 rtl/nn_pkg.sv | 13 +
 rtl/logit_argmax.sv | 96 +++++++++
 tb/tb_logit_argmax.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared classifier constants and types for the logit argmax block.
package nn_pkg;
  localparam int NUM_CLASSES = 10;
  localparam int CLASS_IDX_W = 4;

  typedef int logit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } argmax_state_e;
endpackage

// File: rtl/logit_argmax.sv
// Sequential argmax over a latched logits vector: one signed compare per cycle,
// result held with valid/ready until consumed.
module logit_argmax
  import nn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logit_t                 logits [NUM_CLASSES],
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CLASS_IDX_W-1:0] class_idx,
  output logit_t                 max_val
);

  localparam logic [CLASS_IDX_W-1:0] LAST_IDX = CLASS_IDX_W'(NUM_CLASSES - 1);

  argmax_state_e          state_q, state_d;
  logit_t                 lat_q [NUM_CLASSES];
  logit_t                 lat_d [NUM_CLASSES];
  logic [CLASS_IDX_W-1:0] cnt_q, cnt_d;
  logic [CLASS_IDX_W-1:0] best_idx_q, best_idx_d;
  logit_t                 best_val_q, best_val_d;
  logic [CLASS_IDX_W-1:0] idx_q, idx_d;
  logit_t                 max_q, max_d;
  logic [15:0]            res_cnt_q, res_cnt_d;
  logit_t                 elem;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == HOLD);
  assign class_idx = idx_q;
  assign max_val   = max_q;
  assign elem      = lat_q[cnt_q];

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    cnt_d      = cnt_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    idx_d      = idx_q;
    max_d      = max_q;
    res_cnt_d  = res_cnt_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        lat_d      = logits;
        best_idx_d = '0;
        best_val_d = logits[0];
        cnt_d      = CLASS_IDX_W'(1);
        state_d    = SCAN;
      end
      SCAN: begin
        // Strict > keeps the earliest index on ties; logit_t is signed.
        if (elem > best_val_q) begin
          best_idx_d = cnt_q;
          best_val_d = elem;
        end
        cnt_d = cnt_q + CLASS_IDX_W'(1);
        if (cnt_q == LAST_IDX) begin
          idx_d   = (elem > best_val_q) ? cnt_q : best_idx_q;
          max_d   = (elem > best_val_q) ? elem  : best_val_q;
          state_d = HOLD;
        end
      end
      HOLD: if (out_ready) begin
        res_cnt_d = res_cnt_q + 16'd1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lat_q      <= '{default: '0};
      cnt_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      idx_q      <= '0;
      max_q      <= '0;
      res_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      cnt_q      <= cnt_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      idx_q      <= idx_d;
      max_q      <= max_d;
      res_cnt_q  <= res_cnt_d;
    end
  end

endmodule

// File: tb/tb_logit_argmax.sv
// Directed bench for logit_argmax with hand-computed expected results.
module tb_logit_argmax;
  import nn_pkg::*;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logit_t          logits [NUM_CLASSES];
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [CLASS_IDX_W-1:0] class_idx;
  logit_t          max_val;

  int n_chk = 0;
  int n_err = 0;

  logit_t v [NUM_CLASSES];
  logit_t junk [NUM_CLASSES];
  logit_t int_min;

  logit_argmax dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .logits(logits), .out_valid(out_valid), .out_ready(out_ready),
    .class_idx(class_idx), .max_val(max_val)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept v, scramble the inputs during the scan, stop with out_valid high.
  task automatic run_vec(input string tag, input int ei, input int ev);
    int edges;
    edges = 0;
    while (!in_ready && edges < 20) begin step(); edges++; end
    chk({tag, "_ready_wait"}, (edges < 20) ? 1 : 0, 1);
    logits   = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    logits   = junk;
    chk({tag, "_in_ready_scan"}, in_ready, 0);
    edges = 0;
    while (!out_valid && edges < 20) begin step(); edges++; end
    chk({tag, "_latency"}, edges, 9);
    chk({tag, "_idx"}, class_idx, ei);
    chk({tag, "_val"}, max_val, ev);
  endtask

  initial begin
    int_min = int'(32'h8000_0000);
    junk    = '{default: 32'sh7fff_ffff};
    logits  = '{default: 0};

    // reset
    step(); step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_idx", class_idx, 0);
    chk("rst_val", max_val, 0);
    chk("rst_cnt", dut.res_cnt_q, 0);
    rst = 1'b0;
    step();

    // nominal, out_ready already high so the handshake is the next edge
    v = '{0, 1, 2, 3, 4, 5, 6, 500, 8, 9};
    out_ready = 1'b1;
    run_vec("nom", 7, 500);
    step();
    chk("nom_cnt", dut.res_cnt_q, 1);
    chk("nom_idle_ready", in_ready, 1);
    chk("nom_idle_ovalid", out_valid, 0);
    chk("nom_hold_idx", class_idx, 7);
    chk("nom_hold_val", max_val, 500);

    // tie -> lowest index, then backpressure with new data offered
    v = '{-5, -5, 100, -5, -5, 100, -5, -5, -5, -5};
    out_ready = 1'b0;
    run_vec("tie", 2, 100);
    logits   = '{default: 1000};
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_ovalid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_idx", class_idx, 2);
      chk("bp_val", max_val, 100);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_ovalid", out_valid, 0);
    chk("bp_cnt", dut.res_cnt_q, 2);

    // all negative, extremes included
    v = '{int_min, -3, -7, -1, -9, -20, -4, -100, -8, int_min};
    run_vec("neg", 3, -1);
    step();

    // INT_MAX at the last slot over INT_MIN elsewhere
    v = '{default: int_min};
    v[9] = 32'sh7fff_ffff;
    run_vec("ext", 9, 32'sh7fff_ffff);
    step();
    chk("ext_cnt", dut.res_cnt_q, 4);

    // mid-scan reset on the 4th scan cycle
    v = '{default: 7};
    logits   = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("mrst_pre_ready", in_ready, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_ready", in_ready, 1);
    chk("mrst_ovalid", out_valid, 0);
    chk("mrst_idx", class_idx, 0);
    chk("mrst_val", max_val, 0);
    chk("mrst_cnt", dut.res_cnt_q, 0);
    v = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 42};
    run_vec("post", 9, 42);
    step();
    chk("post_cnt", dut.res_cnt_q, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
